mem_rd_cmd_engine: RTL and testbench

- Responder/executor for the axis_mem_cmd read-command stream. Accepts one (address, length) command at a time and splits it into AXI4 INCR read bursts on an axi_mm master port.
- Forwards the returned read data as a 512-bit axi_stream with last/keep framing, then reports completion on an axis_mem_status stream.
- Sits between the SGD engines' read-command issuers (A/B dataset fetch) and the memory controller.

---
 rtl/mem_rd_pkg.sv | 43 ++++
 rtl/mem_rd_burst_calc.sv | 43 ++++
 rtl/mem_rd_cmd_engine.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_mem_rd_cmd_engine.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// Shared definitions for the memory read-command engine: AXI constants,
// status bit layout, FSM states and the last-beat byte-enable helper.
package mem_rd_pkg;

   // Fixed AXI4 read-address attributes
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [3:0] AXI_CACHE_RD   = 4'b0011;

   // AXI bursts must stay inside one 4 KB page
   localparam int AXI_PAGE_BYTES = 4096;

   // Status byte layout
   localparam int STATUS_DONE_BIT = 7;
   localparam int STATUS_ZERO_BIT = 1;
   localparam int STATUS_ERR_BIT  = 0;

   // Beat counters cover ceil(2^32 / 64) beats
   localparam int BEAT_CNT_W = 27;

   // Widest keep vector the helper can build (DATA_WIDTH up to 2048)
   localparam int KEEP_MAX_W = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      STATUS = 2'd3
   } state_t;

   // Byte enables of the final beat: a zero remainder means a full beat,
   // otherwise only the low 'rem' bytes are valid.
   function automatic logic [KEEP_MAX_W-1:0] keep_from_rem(input logic [7:0] rem);
      logic [KEEP_MAX_W-1:0] k;
      if (rem == 8'd0) begin
         k = '1;
      end else begin
         k = (KEEP_MAX_W'(1) << rem) - KEEP_MAX_W'(1);
      end
      return k;
   endfunction

endpackage

// File: rtl/mem_rd_burst_calc.sv
// Combinational burst sizing: the next burst is the smallest of the beats
// still to issue, the configured burst cap and the beats left in the 4 KB page.
module mem_rd_burst_calc
   import mem_rd_pkg::*;
#(
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_BURST_BEATS = 64
) (
   input  logic [BEAT_CNT_W-1:0] remaining,
   input  logic [11:0]           page_offset,
   output logic [8:0]            burst_beats,
   output logic [7:0]            burst_len
);

   localparam int LOG2_BPB = $clog2(DATA_WIDTH / 8);

   logic [12:0]           page_bytes;
   logic [12:0]           page_beats;
   logic [BEAT_CNT_W-1:0] lim;
   logic                  unused_lim_bits;

   assign page_bytes = 13'(AXI_PAGE_BYTES) - {1'b0, page_offset};
   assign page_beats = page_bytes >> LOG2_BPB;

   // Pick the tightest of the three limits
   always_comb begin
      lim = BEAT_CNT_W'(MAX_BURST_BEATS);
      if ({{(BEAT_CNT_W-13){1'b0}}, page_beats} < lim) begin
         lim = {{(BEAT_CNT_W-13){1'b0}}, page_beats};
      end
      if (remaining < lim) begin
         lim = remaining;
      end
   end

   assign burst_beats = lim[8:0];
   // A 256-beat burst has lim[7:0] = 0, so the wrap yields arlen = 255
   assign burst_len   = lim[7:0] - 8'd1;

   // Upper bits are always zero because lim never exceeds MAX_BURST_BEATS
   assign unused_lim_bits = ^lim[BEAT_CNT_W-1:9];

endmodule

// File: rtl/mem_rd_cmd_engine.sv
// Read-command executor: takes one (address, length) command, splits it
// into 4 KB-safe AXI4 INCR read bursts, forwards the returned beats as a
// framed stream and reports completion on a status stream.
module mem_rd_cmd_engine
   import mem_rd_pkg::*;
#(
   parameter int ADDR_WIDTH      = 33,
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_BURST_BEATS = 64,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ID_WIDTH        = 1,
   parameter int USER_WIDTH      = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,

   // Command stream
   input  logic                    s_cmd_valid,
   output logic                    s_cmd_ready,
   input  logic [63:0]             s_cmd_address,
   input  logic [31:0]             s_cmd_length,

   // AXI read address channel
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arlock,
   output logic [3:0]              m_axi_arqos,
   output logic [3:0]              m_axi_arregion,
   output logic [USER_WIDTH-1:0]   m_axi_aruser,

   // AXI read data channel
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic                    m_axi_rlast,
   input  logic [1:0]              m_axi_rresp,
   input  logic [ID_WIDTH-1:0]     m_axi_rid,
   input  logic [USER_WIDTH-1:0]   m_axi_ruser,

   // AXI write side, unused by a read engine
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic [ID_WIDTH-1:0]     m_axi_awid,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awqos,
   output logic [3:0]              m_axi_awregion,
   output logic [USER_WIDTH-1:0]   m_axi_awuser,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,
   input  logic [ID_WIDTH-1:0]     m_axi_bid,

   // Read data stream
   output logic                    m_axis_valid,
   input  logic                    m_axis_ready,
   output logic [DATA_WIDTH-1:0]   m_axis_data,
   output logic [DATA_WIDTH/8-1:0] m_axis_keep,
   output logic                    m_axis_last,

   // Completion status
   output logic                    m_status_valid,
   input  logic                    m_status_ready,
   output logic [7:0]              m_status_data
);

   localparam int BPB      = DATA_WIDTH / 8;
   localparam int LOG2_BPB = $clog2(BPB);
   localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] cur_addr_reg;
   logic [BEAT_CNT_W-1:0] issue_rem_reg;
   logic [BEAT_CNT_W-1:0] rx_rem_reg;
   logic [LOG2_BPB-1:0]   rem_reg;
   logic [OUT_W-1:0]      outst_reg;
   logic                  err_reg;
   logic [7:0]            status_reg;

   logic                  cmd_hs;
   logic                  ar_hs;
   logic                  r_active;
   logic                  r_beat;
   logic                  r_burst_end;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [32:0]           len_round;
   logic [BEAT_CNT_W-1:0] cmd_beats;
   logic [8:0]            burst_beats;
   logic [7:0]            burst_len;
   logic [7:0]            status_zero;
   logic [7:0]            status_done;
   logic [KEEP_MAX_W-1:0] keep_full;
   logic [BPB-1:0]        keep_last;
   logic                  unused_inputs;

   // ------------------------------------------------------------------
   // Command decode
   // ------------------------------------------------------------------
   assign cmd_hs    = s_cmd_valid & s_cmd_ready;
   assign cmd_addr  = {s_cmd_address[ADDR_WIDTH-1:LOG2_BPB], {LOG2_BPB{1'b0}}};
   assign len_round = {1'b0, s_cmd_length} + 33'(BPB - 1);
   assign cmd_beats = BEAT_CNT_W'(len_round >> LOG2_BPB);

   // ------------------------------------------------------------------
   // Burst sizing
   // ------------------------------------------------------------------
   mem_rd_burst_calc #(
      .DATA_WIDTH      (DATA_WIDTH),
      .MAX_BURST_BEATS (MAX_BURST_BEATS)
   ) u_burst_calc (
      .remaining   (issue_rem_reg),
      .page_offset (cur_addr_reg[11:0]),
      .burst_beats (burst_beats),
      .burst_len   (burst_len)
   );

   // ------------------------------------------------------------------
   // Handshake qualifiers
   // ------------------------------------------------------------------
   assign ar_hs       = m_axi_arvalid & m_axi_arready;
   assign r_active    = (state_reg == ISSUE) || (state_reg == DRAIN);
   assign r_beat      = r_active & m_axi_rvalid & m_axis_ready;
   assign r_burst_end = r_beat & m_axi_rlast;

   // Status words for the two completion flavours
   always_comb begin
      status_zero = 8'd0;
      status_done = 8'd0;
      status_zero[STATUS_DONE_BIT] = 1'b1;
      status_zero[STATUS_ZERO_BIT] = 1'b1;
      status_done[STATUS_DONE_BIT] = 1'b1;
      status_done[STATUS_ERR_BIT]  = err_reg;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_next     = state_reg;
      s_cmd_ready    = 1'b0;
      m_axi_arvalid  = 1'b0;
      m_status_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            // Held low while reset is asserted so nothing is accepted then
            s_cmd_ready = rst_n;
            if (s_cmd_valid && rst_n) begin
               state_next = (s_cmd_length == 32'd0) ? STATUS : ISSUE;
            end
         end
         ISSUE: begin
            m_axi_arvalid = (issue_rem_reg != '0) &&
                            (outst_reg < OUT_W'(MAX_OUTSTANDING));
            if (ar_hs &&
                (issue_rem_reg == {{(BEAT_CNT_W-9){1'b0}}, burst_beats})) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (rx_rem_reg == '0) begin
               state_next = STATUS;
            end
         end
         STATUS: begin
            m_status_valid = 1'b1;
            if (m_status_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Address, beat counters, outstanding-burst count, error and status
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_addr_reg  <= '0;
         issue_rem_reg <= '0;
         rx_rem_reg    <= '0;
         rem_reg       <= '0;
         outst_reg     <= '0;
         err_reg       <= 1'b0;
         status_reg    <= '0;
      end else begin
         if (cmd_hs) begin
            cur_addr_reg  <= cmd_addr;
            issue_rem_reg <= cmd_beats;
            rx_rem_reg    <= cmd_beats;
            rem_reg       <= s_cmd_length[LOG2_BPB-1:0];
            err_reg       <= 1'b0;
            status_reg    <= status_zero;
         end
         if (ar_hs) begin
            cur_addr_reg  <= cur_addr_reg +
                             (ADDR_WIDTH'(burst_beats) << LOG2_BPB);
            issue_rem_reg <= issue_rem_reg -
                             {{(BEAT_CNT_W-9){1'b0}}, burst_beats};
         end
         if (r_beat) begin
            rx_rem_reg <= rx_rem_reg - BEAT_CNT_W'(1);
            if (m_axi_rresp != AXI_RESP_OKAY) begin
               err_reg <= 1'b1;
            end
         end
         // A new burst and a finishing burst in the same cycle cancel out
         if (ar_hs && !r_burst_end) begin
            outst_reg <= outst_reg + OUT_W'(1);
         end else if (!ar_hs && r_burst_end) begin
            outst_reg <= outst_reg - OUT_W'(1);
         end
         if ((state_reg == DRAIN) && (rx_rem_reg == '0)) begin
            status_reg <= status_done;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read address channel: fields come straight from registers, so they
   // stay stable while a request waits for arready.
   // ------------------------------------------------------------------
   assign m_axi_araddr   = cur_addr_reg;
   assign m_axi_arlen    = burst_len;
   assign m_axi_arsize   = 3'(LOG2_BPB);
   assign m_axi_arburst  = AXI_BURST_INCR;
   assign m_axi_arid     = '0;
   assign m_axi_arcache  = AXI_CACHE_RD;
   assign m_axi_arprot   = 3'b000;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_arqos    = 4'd0;
   assign m_axi_arregion = 4'd0;
   assign m_axi_aruser   = '0;

   // ------------------------------------------------------------------
   // Read data pass-through with command-level framing
   // ------------------------------------------------------------------
   assign keep_full    = keep_from_rem(8'(rem_reg));
   assign keep_last    = keep_full[BPB-1:0];

   assign m_axi_rready = r_active & m_axis_ready;
   assign m_axis_valid = r_active & m_axi_rvalid;
   assign m_axis_data  = m_axi_rdata;
   assign m_axis_last  = (rx_rem_reg == BEAT_CNT_W'(1));
   assign m_axis_keep  = m_axis_last ? keep_last : {BPB{1'b1}};

   assign m_status_data = status_reg;

   // ------------------------------------------------------------------
   // Write side tie-off
   // ------------------------------------------------------------------
   assign m_axi_awvalid  = 1'b0;
   assign m_axi_awaddr   = '0;
   assign m_axi_awlen    = 8'd0;
   assign m_axi_awsize   = 3'd0;
   assign m_axi_awburst  = 2'b00;
   assign m_axi_awid     = '0;
   assign m_axi_awcache  = 4'd0;
   assign m_axi_awprot   = 3'd0;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awqos    = 4'd0;
   assign m_axi_awregion = 4'd0;
   assign m_axi_awuser   = '0;
   assign m_axi_wvalid   = 1'b0;
   assign m_axi_wdata    = '0;
   assign m_axi_wstrb    = '0;
   assign m_axi_wlast    = 1'b0;
   assign m_axi_bready   = 1'b1;

   // Inputs and bits that carry no meaning for this engine
   assign unused_inputs = ^{s_cmd_address[63:ADDR_WIDTH],
                            s_cmd_address[LOG2_BPB-1:0],
                            m_axi_rid, m_axi_ruser,
                            m_axi_awready, m_axi_wready,
                            m_axi_bvalid, m_axi_bresp, m_axi_bid,
                            keep_full[KEEP_MAX_W-1:BPB]};

endmodule

// File: tb/tb_mem_rd_cmd_engine.sv
// Scoreboard bench for mem_rd_cmd_engine: a small AXI read slave answers
// bursts with an address-derived pattern; expected ARs, beats and status are
// queued when each command is driven and compared after it completes.
module tb_mem_rd_cmd_engine;

   localparam int AW = 33;
   localparam int DW = 512;
   localparam int KW = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic s_cmd_valid = 1'b0, s_cmd_ready;
   logic [63:0] s_cmd_address = '0;
   logic [31:0] s_cmd_length = '0;
   logic m_axi_arvalid, m_axi_arready = 1'b1;
   logic [AW-1:0] m_axi_araddr;
   logic [7:0] m_axi_arlen;
   logic [2:0] m_axi_arsize, m_axi_arprot;
   logic [1:0] m_axi_arburst;
   logic [0:0] m_axi_arid, m_axi_aruser;
   logic [3:0] m_axi_arcache, m_axi_arqos, m_axi_arregion;
   logic m_axi_arlock;
   logic m_axi_rvalid = 1'b0, m_axi_rready, m_axi_rlast = 1'b0;
   logic [DW-1:0] m_axi_rdata = '0;
   logic [1:0] m_axi_rresp = 2'b00;
   logic [0:0] m_axi_rid = '0, m_axi_ruser = '0;
   logic m_axi_awvalid, m_axi_awlock, m_axi_wvalid, m_axi_wlast, m_axi_bready;
   logic [AW-1:0] m_axi_awaddr;
   logic [7:0] m_axi_awlen;
   logic [2:0] m_axi_awsize, m_axi_awprot;
   logic [1:0] m_axi_awburst;
   logic [0:0] m_axi_awid, m_axi_awuser;
   logic [3:0] m_axi_awcache, m_axi_awqos, m_axi_awregion;
   logic [DW-1:0] m_axi_wdata;
   logic [KW-1:0] m_axi_wstrb;
   logic m_axis_valid, m_axis_ready = 1'b1, m_axis_last;
   logic [DW-1:0] m_axis_data;
   logic [KW-1:0] m_axis_keep;
   logic m_status_valid, m_status_ready = 1'b1;
   logic [7:0] m_status_data;

   mem_rd_cmd_engine dut (
      .clk(clk), .rst_n(rst_n),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arid(m_axi_arid), .m_axi_arcache(m_axi_arcache),
      .m_axi_arprot(m_axi_arprot), .m_axi_arlock(m_axi_arlock),
      .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
      .m_axi_aruser(m_axi_aruser),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
      .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_ruser(m_axi_ruser),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(1'b0),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
      .m_axi_awid(m_axi_awid), .m_axi_awcache(m_axi_awcache),
      .m_axi_awprot(m_axi_awprot), .m_axi_awlock(m_axi_awlock),
      .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
      .m_axi_awuser(m_axi_awuser),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(1'b0),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(1'b0), .m_axi_bready(m_axi_bready),
      .m_axi_bresp(2'b00), .m_axi_bid(1'b0),
      .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
      .m_axis_data(m_axis_data), .m_axis_keep(m_axis_keep), .m_axis_last(m_axis_last),
      .m_status_valid(m_status_valid), .m_status_ready(m_status_ready),
      .m_status_data(m_status_data)
   );

   typedef struct { logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } ar_t;
   typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } beat_t;

   ar_t   ar_exp[$], ar_obs[$];
   beat_t beat_exp[$], beat_obs[$];
   logic [7:0] st_exp[$], st_obs[$];

   int n_cmp = 0;
   int n_err = 0;

   // Read-slave state
   logic [AW-1:0] pend_addr[$];
   int pend_beats[$];
   int r_idx = 0;
   int r_beat_cnt = 0;
   int err_beat = 0;
   bit r_hold = 1'b0;
   bit toggle_en = 1'b0;
   int mirror_bad = 0;

   function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
      logic [DW-1:0] p;
      for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = a[31:0] ^ (32'h9E37_79B9 * 32'(i + 1));
      return p;
   endfunction

   // Memory model and output monitor: drive at the falling edge, sample just after
   always begin
      @(negedge clk);
      if (pend_addr.size() != 0 && !r_hold) begin
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = pattern(pend_addr[0] + AW'(r_idx * 64));
         m_axi_rlast  = (r_idx == pend_beats[0] - 1);
         m_axi_rresp  = (r_beat_cnt + 1 == err_beat) ? 2'b10 : 2'b00;
      end else begin
         m_axi_rvalid = 1'b0;
         m_axi_rlast  = 1'b0;
         m_axi_rresp  = 2'b00;
      end
      m_axis_ready = toggle_en ? ~m_axis_ready : 1'b1;
      #1;
      if (m_axi_rvalid && (m_axis_valid !== 1'b1 || m_axi_rready !== m_axis_ready)) mirror_bad++;
      if (m_axi_rvalid && m_axi_rready) begin
         beat_obs.push_back('{m_axis_data, m_axis_keep, m_axis_last});
         r_beat_cnt++;
         if (m_axi_rlast) begin
            void'(pend_addr.pop_front());
            void'(pend_beats.pop_front());
            r_idx = 0;
         end else begin
            r_idx++;
         end
      end
      if (m_axi_arvalid && m_axi_arready) begin
         ar_obs.push_back('{m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst});
         pend_addr.push_back(m_axi_araddr);
         pend_beats.push_back(int'(m_axi_arlen) + 1);
      end
      if (m_status_valid && m_status_ready) st_obs.push_back(m_status_data);
   end

   // Queue expected ARs and beats for one command, then hand it over
   task automatic send_cmd(input logic [63:0] addr, input logic [31:0] len, output bit accepted);
      logic [AW-1:0] a;
      logic [KW-1:0] k;
      int beats, left, page, b, rem;
      a = addr[AW-1:0] & ~AW'(63);
      beats = int'((longint'(len) + 63) / 64);
      rem = int'(len % 32'd64);
      for (int i = 0; i < beats; i++) begin
         k = '1;
         if (i == beats - 1 && rem != 0) k = (64'd1 << rem) - 64'd1;
         beat_exp.push_back('{pattern(a + AW'(i * 64)), k, (i == beats - 1)});
      end
      left = beats;
      while (left > 0) begin
         page = (4096 - int'(a[11:0])) / 64;
         b = left;
         if (b > 64) b = 64;
         if (b > page) b = page;
         ar_exp.push_back('{a, 8'(b - 1), 3'd6, 2'b01});
         a = a + AW'(b * 64);
         left -= b;
      end
      accepted = 1'b0;
      @(negedge clk);
      s_cmd_valid = 1'b1;
      s_cmd_address = addr;
      s_cmd_length = len;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (s_cmd_ready === 1'b1) begin
            accepted = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      s_cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid got %b want 0", m_axi_arvalid); end
      n_cmp++; if (m_axi_rready !== 1'b0) begin n_err++; $display("FAIL reset_rready got %b want 0", m_axi_rready); end
      n_cmp++; if (m_axis_valid !== 1'b0) begin n_err++; $display("FAIL reset_axis_valid got %b want 0", m_axis_valid); end
      n_cmp++; if (m_status_valid !== 1'b0) begin n_err++; $display("FAIL reset_status_valid got %b want 0", m_status_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if (s_cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b want 1", s_cmd_ready); end
      n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
         n_err++; $display("FAIL write_tieoff got %b want 001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
      end
   endtask

   // One full command: drive, optionally stall R to probe the outstanding cap, then score
   task automatic test_command(input string name, input logic [63:0] addr, input logic [31:0] len,
                               input int err_at, input bit toggle, input bit hold, input logic [7:0] status);
      bit acc;
      ar_t ea, oa;
      beat_t eb, ob;
      ar_obs.delete(); beat_obs.delete(); st_obs.delete();
      err_beat = err_at; toggle_en = toggle; r_hold = hold; r_beat_cnt = 0; mirror_bad = 0;
      st_exp.push_back(status);
      send_cmd(addr, len, acc);
      n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL %s cmd_accept got %b want 1", name, acc); end
      if (hold) begin
         repeat (40) @(negedge clk);
         #2;
         n_cmp++; if (ar_obs.size() != 4) begin n_err++; $display("FAIL %s ar_while_stalled got %0d want 4", name, ar_obs.size()); end
         n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL %s arvalid_at_cap got %b want 0", name, m_axi_arvalid); end
         n_cmp++; if (beat_obs.size() != 0) begin n_err++; $display("FAIL %s beats_while_stalled got %0d want 0", name, beat_obs.size()); end
         r_hold = 1'b0;
      end
      for (int c = 0; c < 3000 && st_obs.size() == 0; c++) @(negedge clk);
      #2;
      n_cmp++; if (st_obs.size() != 1) begin n_err++; $display("FAIL %s status_count got %0d want 1", name, st_obs.size()); end
      n_cmp++; if (ar_obs.size() != ar_exp.size()) begin n_err++; $display("FAIL %s ar_count got %0d want %0d", name, ar_obs.size(), ar_exp.size()); end
      while (ar_exp.size() > 0 && ar_obs.size() > 0) begin
         ea = ar_exp.pop_front(); oa = ar_obs.pop_front();
         n_cmp++; if (oa.addr !== ea.addr) begin n_err++; $display("FAIL %s araddr got %h want %h", name, oa.addr, ea.addr); end
         n_cmp++; if (oa.len !== ea.len) begin n_err++; $display("FAIL %s arlen got %0d want %0d", name, oa.len, ea.len); end
         n_cmp++; if ({oa.size, oa.burst} !== {ea.size, ea.burst}) begin
            n_err++; $display("FAIL %s arsize/burst got %0d/%b want %0d/%b", name, oa.size, oa.burst, ea.size, ea.burst);
         end
      end
      n_cmp++; if (beat_obs.size() != beat_exp.size()) begin n_err++; $display("FAIL %s beat_count got %0d want %0d", name, beat_obs.size(), beat_exp.size()); end
      for (int i = 0; beat_exp.size() > 0 && beat_obs.size() > 0; i++) begin
         eb = beat_exp.pop_front(); ob = beat_obs.pop_front();
         n_cmp++; if (ob.data !== eb.data) begin n_err++; $display("FAIL %s data beat %0d got %h want %h", name, i, ob.data, eb.data); end
         n_cmp++; if (ob.keep !== eb.keep) begin n_err++; $display("FAIL %s keep beat %0d got %h want %h", name, i, ob.keep, eb.keep); end
         n_cmp++; if (ob.last !== eb.last) begin n_err++; $display("FAIL %s last beat %0d got %b want %b", name, i, ob.last, eb.last); end
      end
      if (st_obs.size() > 0) begin
         n_cmp++; if (st_obs[0] !== st_exp[0]) begin n_err++; $display("FAIL %s status got %h want %h", name, st_obs[0], st_exp[0]); end
      end
      if (toggle) begin
         n_cmp++; if (mirror_bad != 0) begin n_err++; $display("FAIL %s rready_mirror bad cycles got %0d want 0", name, mirror_bad); end
      end
      $display("txn %s addr=%h len=%0d status=%h", name, addr, len, (st_obs.size() > 0) ? st_obs[0] : 8'hxx);
      ar_exp.delete(); beat_exp.delete(); st_exp.delete(); st_obs.delete();
      toggle_en = 1'b0; err_beat = 0;
   endtask

   task automatic test_reset_in_status();
      bit acc;
      m_status_ready = 1'b0;
      send_cmd(64'h40, 32'd0, acc);
      n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL rst_status cmd_accept got %b want 1", acc); end
      for (int c = 0; c < 20 && m_status_valid !== 1'b1; c++) @(negedge clk);
      #1;
      n_cmp++; if (m_status_valid !== 1'b1) begin n_err++; $display("FAIL rst_status pending got %b want 1", m_status_valid); end
      n_cmp++; if (m_status_data !== 8'h82) begin n_err++; $display("FAIL rst_status data got %h want 82", m_status_data); end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++; if (m_status_valid !== 1'b0) begin n_err++; $display("FAIL rst_status cleared got %b want 0", m_status_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if (s_cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_status cmd_ready got %b want 1", s_cmd_ready); end
      n_cmp++; if (st_obs.size() != 0) begin n_err++; $display("FAIL rst_status handshakes got %0d want 0", st_obs.size()); end
      $display("txn reset_in_status cmd_ready=%b status_valid=%b", s_cmd_ready, m_status_valid);
      m_status_ready = 1'b1;
      ar_exp.delete(); beat_exp.delete(); st_exp.delete(); st_obs.delete();
   endtask

   initial begin
      test_reset();
      test_command("aligned",     64'h1000, 32'd256,    0, 1'b0, 1'b0, 8'h80);
      test_command("partial",     64'h0,    32'd100,    0, 1'b0, 1'b0, 8'h80);
      test_command("page_split",  64'hF80,  32'd512,    0, 1'b0, 1'b0, 8'h80);
      test_command("outstanding", 64'h0,    32'h8000,   0, 1'b0, 1'b1, 8'h80);
      test_command("rresp_err",   64'h2000, 32'd256,    3, 1'b1, 1'b0, 8'h81);
      test_command("zero_len",    64'h3000, 32'd0,      0, 1'b0, 1'b0, 8'h82);
      test_command("back_to_back",64'h123F, 32'd130,    0, 1'b0, 1'b0, 8'h80);
      test_reset_in_status();
      test_command("after_reset", 64'h1000, 32'd256,    0, 1'b0, 1'b0, 8'h80);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end

endmodule
